// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants, FSM state type and rotate/encode helpers for the interrupt sequencer.
package interrupt_sequencer_pkg;

   localparam int NumIr = 8;
   localparam int LvlW  = 3;

   typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

   // r[i] = v[i + n]: bit n of v lands at position 0.
   function automatic logic [NumIr-1:0] rotate_right(input logic [NumIr-1:0] v,
                                                     input logic [LvlW-1:0]  n);
      logic [NumIr-1:0] r;
      for (int i = 0; i < NumIr; i++) begin
         r[i] = v[LvlW'(i) + n];
      end
      return r;
   endfunction

   function automatic logic [NumIr-1:0] rotate_left(input logic [NumIr-1:0] v,
                                                    input logic [LvlW-1:0]  n);
      logic [NumIr-1:0] r;
      for (int i = 0; i < NumIr; i++) begin
         r[i] = v[LvlW'(i) - n];
      end
      return r;
   endfunction

   // Index of the lowest set bit; 0 when v is empty.
   function automatic logic [LvlW-1:0] encode(input logic [NumIr-1:0] v);
      logic [LvlW-1:0] e;
      e = '0;
      for (int i = NumIr - 1; i >= 0; i--) begin
         if (v[i]) e = LvlW'(i);
      end
      return e;
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request, acknowledge, EOI and vector signals between control logic and the interrupt sequencer.
interface interrupt_sequencer_if;
   import interrupt_sequencer_pkg::*;

   logic [NumIr-1:0] interrupt_req_register;
   logic [NumIr-1:0] interrupt_mask;
   logic             inta;
   logic             eoi_nonspecific;
   logic             eoi_specific;
   logic [LvlW-1:0]  eoi_level;
   logic             rotate_on_eoi;
   logic             auto_eoi_config;
   logic             auto_rotate_config;
   logic [4:0]       vector_base;
   logic             int_out;
   logic             freeze;
   logic [NumIr-1:0] clear_interrupt_req;
   logic [NumIr-1:0] in_service_register;
   logic [7:0]       data_out;
   logic             data_out_en;

   modport master (
      output interrupt_req_register, interrupt_mask, inta, eoi_nonspecific, eoi_specific,
             eoi_level, rotate_on_eoi, auto_eoi_config, auto_rotate_config, vector_base,
      input  int_out, freeze, clear_interrupt_req, in_service_register, data_out, data_out_en
   );

   modport slave (
      input  interrupt_req_register, interrupt_mask, inta, eoi_nonspecific, eoi_specific,
             eoi_level, rotate_on_eoi, auto_eoi_config, auto_rotate_config, vector_base,
      output int_out, freeze, clear_interrupt_req, in_service_register, data_out, data_out_en
   );

endinterface

// File: rtl/interrupt_sequencer_priority_resolver.sv
// Finds the highest-priority set bit of req_i given the current lowest-priority level.
module interrupt_sequencer_priority_resolver
   import interrupt_sequencer_pkg::*;
(
   input  logic [NumIr-1:0] req_i,
   input  logic [LvlW-1:0]  lowest_i,
   output logic             valid_o,
   output logic [LvlW-1:0]  level_o,
   output logic [LvlW-1:0]  rank_o
);

   logic [LvlW-1:0]  base;
   logic [NumIr-1:0] rotated;

   // Rotate so the highest-priority level sits at bit 0; rank 0 is most urgent.
   assign base    = lowest_i + 3'd1;
   assign rotated = rotate_right(req_i, base);
   assign rank_o  = encode(rotated);
   assign level_o = rank_o + base;
   assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_sequencer.sv
// PIC arbitration and INTA sequencing core; owns the ISR and drives the IRR freeze/clear.
// Define ROTATING_PRIORITY_EN to enable the rotating lowest-priority pointer.
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   interrupt_sequencer_if.slave bus
);

   state_e           state_q;
   logic             inta_q;
   logic [LvlW-1:0]  level_q;
   logic             spurious_q;
   logic             int_q;
   logic             freeze_q;
   logic [NumIr-1:0] clear_q;
   logic [NumIr-1:0] isr_q, isr_d;
   logic [7:0]       data_q;
   logic             data_en_q;
   logic [LvlW-1:0]  lowest_prio;

`ifdef ROTATING_PRIORITY_EN
   logic [LvlW-1:0] lowest_q, lowest_d;
   assign lowest_prio = lowest_q;
`else
   logic unused_rotate;
   assign lowest_prio   = 3'd7;
   assign unused_rotate = bus.rotate_on_eoi | bus.auto_rotate_config;
`endif

   logic             inta_rise, inta_fall;
   logic [NumIr-1:0] pending;
   logic             pend_valid, isr_valid, cand_valid;
   logic [LvlW-1:0]  pend_level, pend_rank, isr_level, isr_rank;
   logic             ack_start, aeoi_done;

   assign inta_rise = bus.inta & ~inta_q;
   assign inta_fall = ~bus.inta & inta_q;
   assign pending   = bus.interrupt_req_register & ~bus.interrupt_mask;

   interrupt_sequencer_priority_resolver u_pend_res (
      .req_i    (pending),
      .lowest_i (lowest_prio),
      .valid_o  (pend_valid),
      .level_o  (pend_level),
      .rank_o   (pend_rank)
   );

   interrupt_sequencer_priority_resolver u_isr_res (
      .req_i    (isr_q),
      .lowest_i (lowest_prio),
      .valid_o  (isr_valid),
      .level_o  (isr_level),
      .rank_o   (isr_rank)
   );

   // Fully nested: only a request strictly above every in-service level may interrupt.
   assign cand_valid = pend_valid && (!isr_valid || (pend_rank < isr_rank));
   assign ack_start  = (state_q == StIdle) && inta_rise;
   assign aeoi_done  = (state_q == StAck2) && inta_fall && bus.auto_eoi_config && !spurious_q;

   // Clears are applied before the acknowledge set so a same-cycle set wins.
   always_comb begin
      isr_d = isr_q;
`ifdef ROTATING_PRIORITY_EN
      lowest_d = lowest_q;
`endif
      if (bus.eoi_specific) begin
         isr_d[bus.eoi_level] = 1'b0;
`ifdef ROTATING_PRIORITY_EN
         if (bus.rotate_on_eoi) lowest_d = bus.eoi_level;
`endif
      end else if (bus.eoi_nonspecific && isr_valid) begin
         isr_d[isr_level] = 1'b0;
`ifdef ROTATING_PRIORITY_EN
         if (bus.rotate_on_eoi) lowest_d = isr_level;
`endif
      end
      if (aeoi_done) begin
         isr_d[level_q] = 1'b0;
`ifdef ROTATING_PRIORITY_EN
         if (bus.auto_rotate_config) lowest_d = level_q;
`endif
      end
      if (ack_start && cand_valid) isr_d[pend_level] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         inta_q     <= 1'b0;
         level_q    <= '0;
         spurious_q <= 1'b0;
         int_q      <= 1'b0;
         freeze_q   <= 1'b0;
         clear_q    <= '0;
         isr_q      <= '0;
         data_q     <= '0;
         data_en_q  <= 1'b0;
`ifdef ROTATING_PRIORITY_EN
         lowest_q   <= 3'd7;
`endif
      end else begin
         inta_q  <= bus.inta;
         isr_q   <= isr_d;
         clear_q <= '0;
`ifdef ROTATING_PRIORITY_EN
         lowest_q <= lowest_d;
`endif
         unique case (state_q)
            StIdle: begin
               int_q <= cand_valid;
               if (inta_rise) begin
                  state_q  <= StAck1;
                  freeze_q <= 1'b1;
                  int_q    <= 1'b0;
                  if (cand_valid) begin
                     level_q    <= pend_level;
                     spurious_q <= 1'b0;
                     clear_q    <= 8'b1 << pend_level;
                  end else begin
                     level_q    <= 3'd7;
                     spurious_q <= 1'b1;
                  end
               end
            end
            StAck1: begin
               if (inta_fall) state_q <= StGap;
            end
            StGap: begin
               if (inta_rise) begin
                  state_q   <= StAck2;
                  data_q    <= {bus.vector_base, level_q};
                  data_en_q <= 1'b1;
               end
            end
            StAck2: begin
               if (inta_fall) begin
                  state_q   <= StIdle;
                  freeze_q  <= 1'b0;
                  data_en_q <= 1'b0;
                  data_q    <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.int_out             = int_q;
   assign bus.freeze              = freeze_q;
   assign bus.clear_interrupt_req = clear_q;
   assign bus.in_service_register = isr_q;
   assign bus.data_out            = data_q;
   assign bus.data_out_en         = data_en_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed table-driven bench for interrupt_sequencer plus hand-written multi-cycle sequences.
module tb_interrupt_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   total  = 0;
   int   passed = 0;

   interrupt_sequencer_if bus ();

   interrupt_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] irr;
      logic       inta;
      logic       eoi_ns;
      logic       eoi_sp;
      logic [2:0] lvl;
      logic       rot;
      logic       aeoi;
      logic       int_e;
      logic       frz_e;
      logic [7:0] clr_e;
      logic [7:0] isr_e;
      logic       en_e;
      logic [7:0] data_e;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic [7:0] irr, logic inta, logic ns, logic sp, logic [2:0] lvl,
                               logic rot, logic aeoi, logic int_e, logic frz_e,
                               logic [7:0] clr_e, logic [7:0] isr_e, logic en_e,
                               logic [7:0] data_e);
      vec_t v;
      v.irr = irr; v.inta = inta; v.eoi_ns = ns; v.eoi_sp = sp; v.lvl = lvl; v.rot = rot;
      v.aeoi = aeoi; v.int_e = int_e; v.frz_e = frz_e; v.clr_e = clr_e; v.isr_e = isr_e;
      v.en_e = en_e; v.data_e = data_e;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %02h expected %02h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(input logic [7:0] irr, input logic [7:0] mask, input logic inta);
      bus.interrupt_req_register = irr;
      bus.interrupt_mask         = mask;
      bus.inta                   = inta;
   endtask

   logic [7:0] rot_clr, rot_data;
   logic [2:0] rot_lvl;

   initial begin
`ifdef ROTATING_PRIORITY_EN
      rot_clr = 8'h80; rot_data = 8'h47; rot_lvl = 3'd7;
`else
      rot_clr = 8'h01; rot_data = 8'h40; rot_lvl = 3'd0;
`endif
      //           irr   ia ns sp lvl  rt ae | int frz clr    isr    en data
      vq.push_back(mk(8'h24, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h24, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h20, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h20, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h20, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h04, 1, 8'h42));
      vq.push_back(mk(8'h20, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h04, 1, 8'h42));
      vq.push_back(mk(8'h20, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h20, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h22, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h20, 0, 0, 1, 3'd2, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h20, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      // Spurious acknowledge: request withdrawn before the first INTA rise.
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h47));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      // AEOI on IR5.
      vq.push_back(mk(8'h20, 0, 0, 0, 3'd0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h20, 1, 0, 0, 3'd0, 0, 1, 0, 1, 8'h20, 8'h20, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 1, 8'h00, 8'h20, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 1, 8'h00, 8'h20, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 1, 8'h00, 8'h20, 1, 8'h45));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      // Nest IR1 over IR2, then EOI ordering.
      vq.push_back(mk(8'h04, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h04, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h04, 1, 8'h42));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h02, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h02, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h02, 8'h06, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h06, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h06, 1, 8'h41));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h06, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 1, 1, 3'd5, 0, 0, 0, 0, 8'h00, 8'h04, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      // Specific EOI on the level being set in the same cycle: set wins.
      vq.push_back(mk(8'h08, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h08, 1, 0, 1, 3'd3, 0, 0, 0, 1, 8'h08, 8'h08, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h08, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h08, 1, 8'h43));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h08, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 1, 3'd3, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      // IR0 in service, rotating nonspecific EOI, then IR7 and IR0 together.
      vq.push_back(mk(8'h01, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h01, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h01, 8'h01, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 8'h01, 1, 8'h40));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 1, 0, 3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h81, 0, 0, 0, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00));
      vq.push_back(mk(8'h81, 1, 0, 0, 3'd0, 0, 0, 0, 1, rot_clr, rot_clr, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, rot_clr, 0, 8'h00));
      vq.push_back(mk(8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, rot_clr, 1, rot_data));
      vq.push_back(mk(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, rot_clr, 0, 8'h00));
      vq.push_back(mk(8'h00, 0, 0, 1, rot_lvl, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));

      reset = 1'b1;
      drive(8'h00, 8'h00, 1'b0);
      bus.eoi_nonspecific    = 1'b0;
      bus.eoi_specific       = 1'b0;
      bus.eoi_level          = 3'd0;
      bus.rotate_on_eoi      = 1'b0;
      bus.auto_eoi_config    = 1'b0;
      bus.auto_rotate_config = 1'b0;
      bus.vector_base        = 5'h08;
      step();
      step();
      chk("reset int", {7'd0, bus.int_out}, 8'h00);
      chk("reset freeze", {7'd0, bus.freeze}, 8'h00);
      chk("reset clear", bus.clear_interrupt_req, 8'h00);
      chk("reset isr", bus.in_service_register, 8'h00);
      chk("reset data_en", {7'd0, bus.data_out_en}, 8'h00);
      chk("reset data", bus.data_out, 8'h00);
      reset = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].irr, 8'h00, vq[i].inta);
         bus.eoi_nonspecific = vq[i].eoi_ns;
         bus.eoi_specific    = vq[i].eoi_sp;
         bus.eoi_level       = vq[i].lvl;
         bus.rotate_on_eoi   = vq[i].rot;
         bus.auto_eoi_config = vq[i].aeoi;
         step();
         chk($sformatf("row%0d int", i), {7'd0, bus.int_out}, {7'd0, vq[i].int_e});
         chk($sformatf("row%0d freeze", i), {7'd0, bus.freeze}, {7'd0, vq[i].frz_e});
         chk($sformatf("row%0d clear", i), bus.clear_interrupt_req, vq[i].clr_e);
         chk($sformatf("row%0d isr", i), bus.in_service_register, vq[i].isr_e);
         chk($sformatf("row%0d data_en", i), {7'd0, bus.data_out_en}, {7'd0, vq[i].en_e});
         if (vq[i].en_e) chk($sformatf("row%0d data", i), bus.data_out, vq[i].data_e);
      end
      bus.eoi_nonspecific = 1'b0;
      bus.eoi_specific    = 1'b0;
      bus.rotate_on_eoi   = 1'b0;
      bus.auto_eoi_config = 1'b0;

      // Masked IR2 skipped; mask/IRR changes during the handshake keep the latched level.
      drive(8'h24, 8'h04, 1'b0); step();
      chk("mask int", {7'd0, bus.int_out}, 8'h01);
      drive(8'h24, 8'h04, 1'b1); step();
      chk("mask clear", bus.clear_interrupt_req, 8'h20);
      chk("mask isr", bus.in_service_register, 8'h20);
      drive(8'h00, 8'hff, 1'b0); step();
      drive(8'h00, 8'hff, 1'b1); step();
      chk("latched data_en", {7'd0, bus.data_out_en}, 8'h01);
      chk("latched data", bus.data_out, 8'h45);
      drive(8'h00, 8'h00, 1'b0); step();
      chk("latched freeze off", {7'd0, bus.freeze}, 8'h00);
      bus.eoi_specific = 1'b1; bus.eoi_level = 3'd5; step();
      bus.eoi_specific = 1'b0;
      chk("latched eoi isr", bus.in_service_register, 8'h00);

      // Reset while in GAP abandons the handshake.
      drive(8'h10, 8'h00, 1'b0); step();
      chk("gap int", {7'd0, bus.int_out}, 8'h01);
      drive(8'h10, 8'h00, 1'b1); step();
      chk("gap isr", bus.in_service_register, 8'h10);
      drive(8'h10, 8'h00, 1'b0); step();
      chk("gap freeze", {7'd0, bus.freeze}, 8'h01);
      reset = 1'b1;
      drive(8'h00, 8'h00, 1'b0); step();
      reset = 1'b0;
      chk("gap reset freeze", {7'd0, bus.freeze}, 8'h00);
      chk("gap reset isr", bus.in_service_register, 8'h00);
      chk("gap reset int", {7'd0, bus.int_out}, 8'h00);
      repeat (3) step();
      chk("post reset freeze", {7'd0, bus.freeze}, 8'h00);
      chk("post reset data_en", {7'd0, bus.data_out_en}, 8'h00);

      // Priority pointer back at 7 after reset: IR0 wins over IR7.
      drive(8'h81, 8'h00, 1'b0); step();
      chk("post reset int", {7'd0, bus.int_out}, 8'h01);
      drive(8'h81, 8'h00, 1'b1); step();
      chk("post reset clear", bus.clear_interrupt_req, 8'h01);
      drive(8'h80, 8'h00, 1'b0); step();
      drive(8'h80, 8'h00, 1'b1); step();
      chk("post reset data", bus.data_out, 8'h40);
      drive(8'h80, 8'h00, 1'b0); step();
      chk("post reset isr", bus.in_service_register, 8'h01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
